// File: rtl/rtc_read_sequencer.sv
// rtl/rtc_read_sequencer.sv - RTC bus read-address sequencer
// Walks ADDR_TABLE issuing one read request per entry followed by a dwell hold.
module rtc_read_sequencer #(
  parameter int                        ADDR_W     = 8,
  parameter int                        N_ADDR     = 11,
  parameter logic [N_ADDR*ADDR_W-1:0]  ADDR_TABLE = {8'h43, 8'h42, 8'h41, 8'h28, 8'h27, 8'h26,
                                                     8'h25, 8'h24, 8'h23, 8'h22, 8'h21},
  parameter int                        DWELL      = 74,
  parameter int                        CNT_W      = 12,
  parameter bit                        USE_ACK    = 1'b1,
  parameter int                        ACK_TMO    = 255,
  parameter logic [ADDR_W-1:0]         IDLE_ADDR  = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              escribe,
  input  logic              inicio,
  input  logic              crono,
  input  logic              start,
  input  logic              mode_cont,
  input  logic              rd_ack,
  output logic [ADDR_W-1:0] address,
  output logic              addr_valid,
  output logic              rd_req,
  output logic [3:0]        index,
  output logic              pass_done,
  output logic              ack_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] DWELL_C   = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] ACK_TMO_C = CNT_W'(ACK_TMO);
  localparam logic [3:0]       LAST_IDX  = 4'(N_ADDR - 1);

  state_t             state_q, state_d;
  logic [3:0]         index_q, index_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_err_q, ack_err_d;
  logic               pass_done_q, pass_done_d;

  logic               run_en;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]  table_addr;

  assign run_en  = crono | (~escribe & ~inicio);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    table_addr = IDLE_ADDR;
    for (int i = 0; i < N_ADDR; i++) begin
      if (index_q == 4'(i)) table_addr = ADDR_TABLE[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= 4'd0;
      cnt_q       <= '0;
      ack_err_q   <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      ack_err_q   <= ack_err_d;
      pass_done_q <= pass_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cnt_d       = cnt_q;
    ack_err_d   = ack_err_q;
    pass_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run_en && (mode_cont || start)) begin
          state_d = S_REQ;
          index_d = 4'd0;
        end
      end
      S_REQ: begin
        // Abort takes priority over ack and timeout in the same cycle.
        if (!run_en) begin
          state_d = S_IDLE;
          index_d = 4'd0;
          cnt_d   = '0;
        end else if (!USE_ACK || rd_ack) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_inc == ACK_TMO_C) begin
          ack_err_d = 1'b1;
          state_d   = S_HOLD;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HOLD: begin
        if (!run_en) begin
          state_d = S_IDLE;
          index_d = 4'd0;
          cnt_d   = '0;
        end else if (cnt_inc == DWELL_C) begin
          cnt_d = '0;
          if (index_q != LAST_IDX) begin
            index_d = index_q + 4'd1;
            state_d = S_REQ;
          end else begin
            pass_done_d = 1'b1;
            index_d     = 4'd0;
            state_d     = mode_cont ? S_REQ : S_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        index_d = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    address    = IDLE_ADDR;
    addr_valid = 1'b0;
    rd_req     = 1'b0;
    case (state_q)
      S_REQ: begin
        address    = table_addr;
        addr_valid = 1'b1;
        rd_req     = 1'b1;
      end
      S_HOLD: begin
        address    = table_addr;
        addr_valid = 1'b1;
      end
      default: begin
        address    = IDLE_ADDR;
        addr_valid = 1'b0;
        rd_req     = 1'b0;
      end
    endcase
  end

  assign index     = index_q;
  assign pass_done = pass_done_q;
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// tb/tb_rtc_read_sequencer.sv - directed self-checking bench for rtc_read_sequencer
// DUT a: no ack, DWELL=3. DUT b: ack handshake, DWELL=3, ACK_TMO=8.
module tb_rtc_read_sequencer;

  logic clk = 1'b0;
  logic reset, escribe, inicio, crono, start, mode_cont, rd_ack_b;

  logic [7:0] a_address, b_address;
  logic       a_valid, a_req, a_pd, a_err;
  logic       b_valid, b_req, b_pd, b_err;
  logic [3:0] a_index, b_index;

  logic [7:0] tbl [0:10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                             8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

  int errors = 0;
  int checks = 0;
  int e, ph, n;

  always #5 clk = ~clk;

  rtc_read_sequencer #(.USE_ACK(1'b0), .DWELL(3)) u_dut_a (
    .clk(clk), .reset(reset), .escribe(escribe), .inicio(inicio), .crono(crono),
    .start(start), .mode_cont(mode_cont), .rd_ack(1'b0),
    .address(a_address), .addr_valid(a_valid), .rd_req(a_req), .index(a_index),
    .pass_done(a_pd), .ack_err(a_err)
  );

  rtc_read_sequencer #(.USE_ACK(1'b1), .DWELL(3), .ACK_TMO(8)) u_dut_b (
    .clk(clk), .reset(reset), .escribe(escribe), .inicio(inicio), .crono(crono),
    .start(start), .mode_cont(mode_cont), .rd_ack(rd_ack_b),
    .address(b_address), .addr_valid(b_valid), .rd_req(b_req), .index(b_index),
    .pass_done(b_pd), .ack_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; escribe = 1'b0; inicio = 1'b0; crono = 1'b0;
    start = 1'b0; mode_cont = 1'b0; rd_ack_b = 1'b0;
    tick;
    chk("rst_addr", a_address, 8'hFF);
    chk("rst_valid", a_valid, 0);
    chk("rst_req", a_req, 0);
    chk("rst_index", a_index, 0);
    chk("rst_pd", a_pd, 0);
    chk("rst_err", b_err, 0);
    reset = 1'b0;
    tick;
    chk("idle_no_trigger", a_valid, 0);

    // single pass, no ack: 11 entries x 4 cycles; b times out on entry 0
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 44; k++) begin
      e = k / 4;
      ph = k % 4;
      chk("t2_addr", a_address, tbl[e]);
      chk("t2_valid", a_valid, 1);
      chk("t2_req", a_req, (ph == 0));
      chk("t2_index", a_index, e);
      chk("t2_pd", a_pd, 0);
      if (k == 7) begin
        chk("t4_req_last", b_req, 1);
        chk("t4_err_pre", b_err, 0);
      end
      if (k == 8) begin
        chk("t4_err_set", b_err, 1);
        chk("t4_hold_req", b_req, 0);
        chk("t4_hold_addr", b_address, 8'h21);
        chk("t4_hold_idx", b_index, 0);
      end
      if (k == 11) begin
        chk("t4_next_idx", b_index, 1);
        chk("t4_next_addr", b_address, 8'h22);
        chk("t4_next_req", b_req, 1);
      end
      tick;
    end
    chk("t2_pd_pulse", a_pd, 1);
    chk("t2_end_valid", a_valid, 0);
    chk("t2_end_addr", a_address, 8'hFF);
    chk("t2_end_index", a_index, 0);
    tick;
    chk("t2_pd_single", a_pd, 0);
    chk("t2_stay_idle", a_valid, 0);
    chk("t4_err_sticky", b_err, 1);

    // ack delayed to 5th REQ cycle
    reset = 1'b1;
    #1;
    chk("t4_err_cleared", b_err, 0);
    reset = 1'b0;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_req", b_req, 1);
      chk("t3_addr", b_address, 8'h21);
      chk("t3_valid", b_valid, 1);
      if (k == 4) rd_ack_b = 1'b1;
      tick;
    end
    rd_ack_b = 1'b0;
    for (int k = 5; k < 8; k++) begin
      chk("t3_hold_req", b_req, 0);
      chk("t3_hold_addr", b_address, 8'h21);
      chk("t3_hold_valid", b_valid, 1);
      tick;
    end
    chk("t3_next_addr", b_address, 8'h22);
    chk("t3_next_req", b_req, 1);
    chk("t3_no_err", b_err, 0);

    // continuous mode, abort by escribe during entry 8'h25
    reset = 1'b1;
    mode_cont = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    chk("t5_first_addr", a_address, 8'h21);
    chk("t5_first_req", a_req, 1);
    repeat (17) tick;
    chk("t5_at25_addr", a_address, 8'h25);
    chk("t5_at25_idx", a_index, 4);
    escribe = 1'b1;
    tick;
    chk("t5_abort_valid", a_valid, 0);
    chk("t5_abort_addr", a_address, 8'hFF);
    chk("t5_abort_idx", a_index, 0);
    chk("t5_abort_pd", a_pd, 0);
    tick;
    chk("t5_blocked", a_valid, 0);
    escribe = 1'b0;
    tick;
    chk("t5_restart_addr", a_address, 8'h21);
    chk("t5_restart_req", a_req, 1);
    chk("t5_restart_idx", a_index, 0);

    // async reset in HOLD of index 5
    repeat (21) tick;
    chk("t1_pre_idx", a_index, 5);
    chk("t1_pre_req", a_req, 0);
    chk("t1_pre_valid", a_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("t1_addr", a_address, 8'hFF);
    chk("t1_valid", a_valid, 0);
    chk("t1_index", a_index, 0);

    // crono overrides escribe/inicio; continuous looping
    crono = 1'b1; escribe = 1'b1; inicio = 1'b1;
    reset = 1'b0;
    tick;
    chk("t6_start_valid", a_valid, 1);
    chk("t6_start_addr", a_address, 8'h21);
    n = 0;
    do begin tick; n++; end while (!a_pd && n < 200);
    chk("t6_first_period", n, 44);
    chk("t6_loop_req", a_req, 1);
    chk("t6_loop_idx", a_index, 0);
    n = 0;
    do begin tick; n++; end while (!a_pd && n < 200);
    chk("t6_second_period", n, 44);

    // clearing mode_cont lets the current pass finish, then IDLE
    mode_cont = 1'b0;
    n = 0;
    do begin tick; n++; end while (!a_pd && n < 200);
    chk("t6_final_period", n, 44);
    chk("t6_final_idle", a_valid, 0);
    tick;
    chk("t6_stays_idle", a_valid, 0);
    chk("t6_pd_drop", a_pd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
